sram_ctrl: RTL and testbench

//  Responder side of the LSU external-memory request/stall interface. Turns one 32-bit
//  LSU access into two 16-bit accesses on the off-chip 256Kx16 async SRAM (IS61WV25616

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_ctrl_if.sv | 22 ++
 rtl/sram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and widths for the LSU-to-async-SRAM bridge.
package sram_pkg;

  localparam int unsigned SRAM_AW  = 18;
  localparam int unsigned SRAM_DW  = 16;
  localparam int unsigned LSU_DW   = 32;
  localparam int unsigned BMASK_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO_SETUP,
    ST_LO_ACC,
    ST_HI_SETUP,
    ST_HI_ACC,
    ST_DONE
  } sram_state_e;

  // One accepted LSU access, frozen for the duration of the transfer.
  typedef struct packed {
    logic                 wren;
    logic [SRAM_AW-2:0]   waddr;
    logic [BMASK_W-1:0]   bmask;
    logic [LSU_DW-1:0]    wdata;
  } lsu_req_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// LSU request/stall handshake between the load-store unit and the SRAM controller.
interface sram_ctrl_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              i_req;
  logic              i_wren;
  logic [ADDR_W-1:0] i_addr;
  logic [3:0]        i_bmask;
  logic [31:0]       i_wdata;
  logic [31:0]       o_rdata;
  logic              o_stall;

  modport master (
    output i_req, i_wren, i_addr, i_bmask, i_wdata,
    input  o_rdata, o_stall
  );

  modport slave (
    input  i_req, i_wren, i_addr, i_bmask, i_wdata,
    output o_rdata, o_stall
  );
endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit LSU access into two 16-bit async-SRAM accesses, stalling the core meanwhile.
// All SRAM pins are registered; WE-controlled writes keep address/data stable while WE_N is low.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_ctrl_if.slave         lsu,
  output logic [SRAM_AW-1:0] o_SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] o_SRAM_DQ,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  lsu_req_t           req_q, req_d, req_in, cur;
  logic [LSU_DW-1:0]  rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic               lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic               acc_last, hi, active, setup, acc;
  logic               addr_lo_unused;

  assign addr_lo_unused = ^lsu.i_addr[1:0];

  // Next state plus pin values decoded from the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;

    req_in.wren  = lsu.i_wren;
    req_in.waddr = (SRAM_AW-1)'(lsu.i_addr[ADDR_W-1:2]);
    req_in.bmask = lsu.i_bmask;
    req_in.wdata = lsu.i_wdata;
    cur          = (state_q == ST_IDLE) ? req_in : req_q;
    acc_last     = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (lsu.i_req) begin
          req_d = req_in;
          if (!req_in.wren || (|req_in.bmask[1:0])) state_d = ST_LO_SETUP;
          else if (|req_in.bmask[3:2])              state_d = ST_HI_SETUP;
          else                                      state_d = ST_DONE;
        end
      end
      ST_LO_SETUP: begin
        state_d = ST_LO_ACC;
        cnt_d   = '0;
      end
      ST_LO_ACC: begin
        if (acc_last) begin
          if (!req_q.wren) rdata_d[15:0] = o_SRAM_DQ;
          state_d = (!req_q.wren || (|req_q.bmask[3:2])) ? ST_HI_SETUP : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI_SETUP: begin
        state_d = ST_HI_ACC;
        cnt_d   = '0;
      end
      ST_HI_ACC: begin
        if (acc_last) begin
          if (!req_q.wren) rdata_d[31:16] = o_SRAM_DQ;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    hi     = (state_d == ST_HI_SETUP) || (state_d == ST_HI_ACC);
    setup  = (state_d == ST_LO_SETUP) || (state_d == ST_HI_SETUP);
    acc    = (state_d == ST_LO_ACC)   || (state_d == ST_HI_ACC);
    active = setup || acc;

    // Address and write data only move on entry to SETUP, never under a low WE_N.
    if (setup) begin
      addr_d   = SRAM_AW'({cur.waddr, hi});
      dq_out_d = hi ? cur.wdata[31:16] : cur.wdata[15:0];
    end

    if (active) begin
      ce_n_d = 1'b0;
      if (cur.wren) begin
        dq_oe_d = 1'b1;
        we_n_d  = ~acc;
        lb_n_d  = hi ? ~cur.bmask[2] : ~cur.bmask[0];
        ub_n_d  = hi ? ~cur.bmask[3] : ~cur.bmask[1];
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
    end
  end

  assign o_SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = lb_n_q;
  assign o_SRAM_UB_N = ub_n_q;
  assign lsu.o_rdata = rdata_q;
  // The core commits in DONE, so stall drops there even with i_req still high.
  assign lsu.o_stall = i_rst & lsu.i_req & (state_q != ST_DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (WAIT_CYCLES=1 and 3) each on a behavioural async SRAM.
module tb_sram_ctrl;

  logic clk;
  logic rst_n;
  logic req0, req1;
  logic        t_wren;
  logic [18:0] t_addr;
  logic [3:0]  t_bmask;
  logic [31:0] t_wdata;
  int          sel;

  int checks;
  int fails;

  logic [15:0] mem [2][1024];
  int          ce_cyc [2];
  int          we_cyc [2];
  logic        prev_we_low [2];
  logic [17:0] prev_a [2];
  logic [15:0] prev_d [2];

  sram_ctrl_if #(.ADDR_W(19)) lsu0 ();
  sram_ctrl_if #(.ADDR_W(19)) lsu1 ();

  assign lsu0.i_req   = req0;
  assign lsu0.i_wren  = t_wren;
  assign lsu0.i_addr  = t_addr;
  assign lsu0.i_bmask = t_bmask;
  assign lsu0.i_wdata = t_wdata;
  assign lsu1.i_req   = req1;
  assign lsu1.i_wren  = t_wren;
  assign lsu1.i_addr  = t_addr;
  assign lsu1.i_bmask = t_bmask;
  assign lsu1.i_wdata = t_wdata;

  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic ce_n0, we_n0, oe_n0, lb_n0, ub_n0;
  logic ce_n1, we_n1, oe_n1, lb_n1, ub_n1;

  sram_ctrl #(.WAIT_CYCLES(1), .ADDR_W(19)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .lsu(lsu0),
    .o_SRAM_ADDR(sa0), .o_SRAM_DQ(dq0), .o_SRAM_CE_N(ce_n0), .o_SRAM_WE_N(we_n0),
    .o_SRAM_OE_N(oe_n0), .o_SRAM_LB_N(lb_n0), .o_SRAM_UB_N(ub_n0)
  );

  sram_ctrl #(.WAIT_CYCLES(3), .ADDR_W(19)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .lsu(lsu1),
    .o_SRAM_ADDR(sa1), .o_SRAM_DQ(dq1), .o_SRAM_CE_N(ce_n1), .o_SRAM_WE_N(we_n1),
    .o_SRAM_OE_N(oe_n1), .o_SRAM_LB_N(lb_n1), .o_SRAM_UB_N(ub_n1)
  );

  // Async SRAM read path: drives the bus only while selected and output-enabled.
  assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? mem[0][sa0[9:0]] : 16'hzzzz;
  assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? mem[1][sa1[9:0]] : 16'hzzzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // SRAM write/timing model, evaluated once per cycle at the falling edge.
  task automatic mon(input int i, input logic ce, input logic we, input logic oe, input logic lb,
                     input logic ub, input logic [17:0] a, input logic [15:0] d);
    if (!ce) ce_cyc[i]++;
    if (!ce && !we) begin
      we_cyc[i]++;
      if (prev_we_low[i]) begin
        checks++;
        if (a !== prev_a[i] || d !== prev_d[i]) begin
          fails++;
          $display("FAIL we_stable[%0d] addr=%h data=%h required addr=%h data=%h",
                   i, a, d, prev_a[i], prev_d[i]);
        end
      end
      if (!lb) mem[i][a[9:0]][7:0]  = d[7:0];
      if (!ub) mem[i][a[9:0]][15:8] = d[15:8];
    end
    if (!ce && !oe) begin
      checks++;
      if (!we || d !== mem[i][a[9:0]]) begin
        fails++;
        $display("FAIL read_bus[%0d] we_n=%b dq=%h required we_n=1 dq=%h", i, we, d, mem[i][a[9:0]]);
      end
    end
    prev_we_low[i] = !ce && !we;
    prev_a[i]      = a;
    prev_d[i]      = d;
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, ce_n0, we_n0, oe_n0, lb_n0, ub_n0, sa0, dq0);
    mon(1, ce_n1, we_n1, oe_n1, lb_n1, ub_n1, sa1, dq1);
  endtask

  function automatic logic cur_stall();
    return (sel == 1) ? lsu1.o_stall : lsu0.o_stall;
  endfunction

  function automatic logic [31:0] cur_rdata();
    return (sel == 1) ? lsu1.o_rdata : lsu0.o_rdata;
  endfunction

  // One LSU access; inputs are scrambled after acceptance to prove they were registered.
  task automatic txn(input int s, input logic wr, input logic [18:0] a, input logic [3:0] m,
                     input logic [31:0] d, input bit keep, output int stalls, output logic [31:0] rd);
    step();
    sel = s; t_wren = wr; t_addr = a; t_bmask = m; t_wdata = d;
    if (s == 1) req1 = 1'b1; else req0 = 1'b1;
    #1;
    stalls = 0;
    while (cur_stall() && stalls < 40) begin
      stalls++;
      step();
      t_wren = ~wr; t_addr = ~a; t_bmask = ~m; t_wdata = ~d;
      #1;
    end
    rd = cur_rdata();
    if (!keep) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [3:0]  m;
    logic [31:0] d;
    int          stall;
    int          ce;
    int          we;
    logic [31:0] rd;
  } vec_t;

  vec_t        vec [12];
  int          st, st2, ce_s, we_s, k;
  logic [31:0] rd, rd2;

  initial begin
    vec[0]  = '{1'b1, 19'h00010, 4'hF, 32'hDEADBEEF, 5, 4, 2, 32'h0};
    vec[1]  = '{1'b0, 19'h00010, 4'h0, 32'h0,        5, 4, 0, 32'hDEADBEEF};
    vec[2]  = '{1'b1, 19'h00010, 4'h4, 32'h00AA0000, 3, 2, 1, 32'h0};
    vec[3]  = '{1'b0, 19'h00010, 4'hF, 32'h0,        5, 4, 0, 32'hDEAABEEF};
    vec[4]  = '{1'b1, 19'h00010, 4'h0, 32'hFFFFFFFF, 1, 0, 0, 32'h0};
    vec[5]  = '{1'b0, 19'h00010, 4'h0, 32'h0,        5, 4, 0, 32'hDEAABEEF};
    vec[6]  = '{1'b1, 19'h00000, 4'h3, 32'h12345678, 3, 2, 1, 32'h0};
    vec[7]  = '{1'b1, 19'h00004, 4'hF, 32'hCAFEF00D, 5, 4, 2, 32'h0};
    vec[8]  = '{1'b1, 19'h00008, 4'hA, 32'h11223344, 5, 4, 2, 32'h0};
    vec[9]  = '{1'b0, 19'h00008, 4'h0, 32'h0,        5, 4, 0, 32'h11003300};
    vec[10] = '{1'b1, 19'h0000C, 4'h8, 32'hAB000000, 3, 2, 1, 32'h0};
    vec[11] = '{1'b0, 19'h0000C, 4'h0, 32'h0,        5, 4, 0, 32'hAB000000};

    checks = 0; fails = 0; sel = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 1024; j++) mem[i][j] = 16'h0;
      ce_cyc[i] = 0; we_cyc[i] = 0; prev_we_low[i] = 1'b0; prev_a[i] = '0; prev_d[i] = '0;
    end
    t_wren = 1'b0; t_addr = '0; t_bmask = '0; t_wdata = '0;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0;

    // Reset state, with a request already pending.
    step(); step();
    chk("rst_rdata", lsu0.o_rdata, 32'h0);
    chk("rst_stall", 32'(lsu0.o_stall), 32'h0);
    chk("rst_addr",  32'(sa0), 32'h0);
    chk("rst_pins",  32'({ce_n0, we_n0, oe_n0, lb_n0, ub_n0}), 32'h1F);
    chk("rst_pins1", 32'({ce_n1, we_n1, oe_n1, lb_n1, ub_n1}), 32'h1F);
    req0 = 1'b0;
    rst_n = 1'b1;

    for (k = 0; k < 12; k++) begin
      ce_s = ce_cyc[0]; we_s = we_cyc[0];
      txn(0, vec[k].wr, vec[k].addr, vec[k].m, vec[k].d, 1'b0, st, rd);
      chk($sformatf("v%0d_stall", k), 32'(st), 32'(vec[k].stall));
      chk($sformatf("v%0d_ce_cyc", k), 32'(ce_cyc[0] - ce_s), 32'(vec[k].ce));
      chk($sformatf("v%0d_we_cyc", k), 32'(we_cyc[0] - we_s), 32'(vec[k].we));
      if (!vec[k].wr) chk($sformatf("v%0d_rdata", k), rd, vec[k].rd);
    end
    chk("mem_8",  32'(mem[0][8]),  32'h0000BEEF);
    chk("mem_9",  32'(mem[0][9]),  32'h0000DEAA);
    chk("mem_0",  32'(mem[0][0]),  32'h00005678);
    chk("mem_1",  32'(mem[0][1]),  32'h00000000);
    chk("mem_3",  32'(mem[0][3]),  32'h0000CAFE);

    // Back-to-back reads with i_req held through DONE.
    txn(0, 1'b0, 19'h00000, 4'hF, 32'h0, 1'b1, st, rd);
    txn(0, 1'b0, 19'h00004, 4'hF, 32'h0, 1'b0, st2, rd2);
    chk("b2b_stall1", 32'(st),  32'd5);
    chk("b2b_rdata1", rd,       32'h00005678);
    chk("b2b_stall2", 32'(st2), 32'd5);
    chk("b2b_rdata2", rd2,      32'hCAFEF00D);
    step(); step();
    chk("b2b_no_dup", 32'({ce_n0, lsu0.o_stall}), 32'h2);

    // Asynchronous reset while the low half of a write is strobing.
    step();
    sel = 0; t_wren = 1'b1; t_addr = 19'h00020; t_bmask = 4'hF; t_wdata = 32'h55AA55AA;
    req0 = 1'b1;
    for (int n = 0; n < 10 && we_n0; n++) step();
    chk("abort_in_acc", 32'(we_n0), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort_pins",  32'({ce_n0, we_n0, oe_n0, lb_n0, ub_n0}), 32'h1F);
    chk("abort_addr",  32'(sa0), 32'h0);
    chk("abort_stall", 32'(lsu0.o_stall), 32'h0);
    chk("abort_rdata", lsu0.o_rdata, 32'h0);
    req0 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    txn(0, 1'b0, 19'h00010, 4'hF, 32'h0, 1'b0, st, rd);
    chk("post_rst_stall", 32'(st), 32'd5);
    chk("post_rst_rdata", rd, 32'hDEAABEEF);

    // Slow SRAM instance: three access cycles per half.
    ce_s = ce_cyc[1]; we_s = we_cyc[1];
    txn(1, 1'b1, 19'h00010, 4'hF, 32'hDEADBEEF, 1'b0, st, rd);
    chk("w3_wr_stall",  32'(st), 32'd9);
    chk("w3_wr_ce_cyc", 32'(ce_cyc[1] - ce_s), 32'd8);
    chk("w3_wr_we_cyc", 32'(we_cyc[1] - we_s), 32'd6);
    chk("w3_mem_8", 32'(mem[1][8]), 32'h0000BEEF);
    chk("w3_mem_9", 32'(mem[1][9]), 32'h0000DEAD);
    txn(1, 1'b0, 19'h00010, 4'hF, 32'h0, 1'b0, st, rd);
    chk("w3_rd_stall", 32'(st), 32'd9);
    chk("w3_rd_rdata", rd, 32'hDEADBEEF);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
